// File: rtl/rv32_multicycle_ctrl.sv
// Multicycle control FSM for the RV32I core: sequences FETCH/DECODE/EXEC/MEM/WB
// over a shared datapath with a single variable-latency memory port.
module rv32_multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        breq,
    input  logic        brlt,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        pc_we,
    output logic        ir_we,
    output logic        reg_we,
    output logic        pc_sel,
    output logic [2:0]  imm_sel,
    output logic        br_un,
    output logic        a_sel,
    output logic        b_sel,
    output logic [3:0]  alu_sel,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic [2:0]  state
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    state_t      cur_state;
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic        is_load, is_store, is_branch, is_jump;
    logic        legal, taken;
    logic [2:0]  dec_imm;
    logic        dec_a, dec_b;
    logic [3:0]  dec_alu;
    logic        unused_fields;

    assign opcode        = instr[6:0];
    assign funct3        = instr[14:12];
    assign funct7        = instr[31:25];
    assign unused_fields = ^{instr[24:15], instr[11:7]};
    assign is_load       = (opcode == OPC_LOAD);
    assign is_store      = (opcode == OPC_STORE);
    assign is_branch     = (opcode == OPC_BRANCH);
    assign is_jump       = (opcode == OPC_JAL) || (opcode == OPC_JALR);

    // alt selects SUB for funct3 000 and SRA for funct3 101
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? 4'd1 : 4'd0;
            3'b001:  return 4'd2;
            3'b010:  return 4'd3;
            3'b011:  return 4'd4;
            3'b100:  return 4'd5;
            3'b101:  return alt ? 4'd7 : 4'd6;
            3'b110:  return 4'd8;
            default: return 4'd9;
        endcase
    endfunction

    always_comb begin
        legal   = 1'b0;
        dec_imm = 3'd0;
        dec_a   = 1'b0;
        dec_b   = 1'b0;
        dec_alu = ALU_ADD;
        case (opcode)
            OPC_R: begin
                legal   = (funct7 == 7'b0000000) ||
                          (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
                dec_alu = alu_from_funct3(funct3, funct7[5]);
            end
            OPC_IMM: begin
                if (funct3 == 3'b001)
                    legal = (funct7 == 7'b0000000);
                else if (funct3 == 3'b101)
                    legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                else
                    legal = 1'b1;
                dec_b   = 1'b1;
                dec_alu = alu_from_funct3(funct3, funct3 == 3'b101 && funct7[5]);
            end
            OPC_LOAD: begin
                legal = (funct3 == 3'b010);
                dec_b = 1'b1;
            end
            OPC_STORE: begin
                legal   = (funct3 == 3'b010);
                dec_imm = 3'd1;
                dec_b   = 1'b1;
            end
            OPC_BRANCH: begin
                legal   = (funct3 != 3'b010) && (funct3 != 3'b011);
                dec_imm = 3'd2;
                dec_a   = 1'b1;
                dec_b   = 1'b1;
            end
            OPC_JAL: begin
                legal   = 1'b1;
                dec_imm = 3'd4;
                dec_a   = 1'b1;
                dec_b   = 1'b1;
            end
            OPC_JALR: begin
                legal = (funct3 == 3'b000);
                dec_b = 1'b1;
            end
            OPC_LUI: begin
                legal   = 1'b1;
                dec_imm = 3'd3;
                dec_b   = 1'b1;
                dec_alu = ALU_PASSB;
            end
            OPC_AUIPC: begin
                legal   = 1'b1;
                dec_imm = 3'd3;
                dec_a   = 1'b1;
                dec_b   = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        case (funct3)
            3'b000:         taken = breq;
            3'b001:         taken = !breq;
            3'b100, 3'b110: taken = brlt;
            3'b101, 3'b111: taken = !brlt;
            default:        taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= S_FETCH;
            illegal   <= 1'b0;
        end else begin
            case (cur_state)
                S_FETCH:  if (mem_ready) cur_state <= S_DECODE;
                S_DECODE: begin
                    if (legal) begin
                        cur_state <= S_EXEC;
                    end else begin
                        cur_state <= S_TRAP;
                        illegal   <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (is_branch)
                        cur_state <= S_FETCH;
                    else if (is_load || is_store)
                        cur_state <= S_MEM;
                    else
                        cur_state <= S_WB;
                end
                S_MEM:    if (mem_ready) cur_state <= is_store ? S_FETCH : S_WB;
                S_WB:     cur_state <= S_FETCH;
                S_TRAP:   cur_state <= S_TRAP;
                default:  cur_state <= S_FETCH;
            endcase
        end
    end

    // Operand and ALU selects stay valid from EXEC through WB so MEM/WB reuse the EXEC result
    always_comb begin
        mem_req = 1'b0;
        mem_we  = 1'b0;
        pc_we   = 1'b0;
        ir_we   = 1'b0;
        reg_we  = 1'b0;
        pc_sel  = 1'b0;
        imm_sel = 3'd0;
        br_un   = 1'b0;
        a_sel   = 1'b0;
        b_sel   = 1'b0;
        alu_sel = ALU_ADD;
        wb_sel  = 2'd0;
        case (cur_state)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            S_DECODE: imm_sel = dec_imm;
            S_EXEC: begin
                imm_sel = dec_imm;
                a_sel   = dec_a;
                b_sel   = dec_b;
                alu_sel = dec_alu;
                if (is_branch) begin
                    br_un  = funct3[1];
                    pc_we  = 1'b1;
                    pc_sel = taken;
                end
            end
            S_MEM: begin
                imm_sel = dec_imm;
                a_sel   = dec_a;
                b_sel   = dec_b;
                alu_sel = dec_alu;
                mem_req = 1'b1;
                mem_we  = is_store;
                pc_we   = is_store && mem_ready;
            end
            S_WB: begin
                imm_sel = dec_imm;
                a_sel   = dec_a;
                b_sel   = dec_b;
                alu_sel = dec_alu;
                reg_we  = 1'b1;
                pc_we   = 1'b1;
                pc_sel  = is_jump;
                wb_sel  = is_load ? 2'd0 : (is_jump ? 2'd2 : 2'd1);
            end
            default: ;
        endcase
        if (rst) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            pc_we   = 1'b0;
            ir_we   = 1'b0;
            reg_we  = 1'b0;
        end
    end

    assign state = cur_state;
endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// Self-checking bench for rv32_multicycle_ctrl: directed scenarios plus random
// instruction streams checked cycle by cycle against an instruction-level model.
module tb_rv32_multicycle_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        breq = 1'b0;
    logic        brlt = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, pc_we, ir_we, reg_we, pc_sel;
    logic [2:0]  imm_sel;
    logic        br_un, a_sel, b_sel;
    logic [3:0]  alu_sel;
    logic [1:0]  wb_sel;
    logic        illegal;
    logic [2:0]  state;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    rv32_multicycle_ctrl dut (
        .clk(clk), .rst(rst), .instr(instr), .breq(breq), .brlt(brlt),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .pc_we(pc_we),
        .ir_we(ir_we), .reg_we(reg_we), .pc_sel(pc_sel), .imm_sel(imm_sel),
        .br_un(br_un), .a_sel(a_sel), .b_sel(b_sel), .alu_sel(alu_sel),
        .wb_sel(wb_sel), .illegal(illegal), .state(state)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       mreq, mwe, pcwe, irwe, regwe, pcsel;
        logic [2:0] imm;
        logic       brun, asel, bsel;
        logic [3:0] alu;
        logic [1:0] wb;
        logic       ill;
    } exp_t;

    typedef struct packed {
        logic       legal;
        logic [3:0] cls;
        logic [2:0] imm;
        logic       asel, bsel;
        logic [3:0] alu;
    } ref_t;

    localparam logic [3:0] C_R = 0, C_OPI = 1, C_LW = 2, C_SW = 3, C_BR = 4,
                           C_JAL = 5, C_JALR = 6, C_LUI = 7, C_AUIPC = 8, C_BAD = 9;

    exp_t obs;
    assign obs = {state, mem_req, mem_we, pc_we, ir_we, reg_we, pc_sel, imm_sel,
                  br_un, a_sel, b_sel, alu_sel, wb_sel, illegal};

    // Instruction-level reference: what class, legality and datapath selects each instruction needs
    function automatic ref_t ref_decode(input logic [31:0] ins);
        ref_t       r;
        logic [31:0] alu_table;
        logic [2:0] f3;
        logic [6:0] f7;
        alu_table = 32'h98654320;
        f3 = ins[14:12];
        f7 = ins[31:25];
        r  = '0;
        case (ins[6:0])
            7'h33: begin
                r.cls   = C_R;
                r.legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                r.alu   = alu_table[f3*4 +: 4];
                if (f7 == 7'h20 && f3 == 3'd0) r.alu = 4'd1;
                if (f7 == 7'h20 && f3 == 3'd5) r.alu = 4'd7;
            end
            7'h13: begin
                r.cls   = C_OPI;
                r.bsel  = 1'b1;
                r.legal = (f3 == 3'd1) ? (f7 == 7'h00) :
                          (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
                r.alu   = alu_table[f3*4 +: 4];
                if (f3 == 3'd5 && f7 == 7'h20) r.alu = 4'd7;
            end
            7'h03: begin r.cls = C_LW;  r.bsel = 1'b1; r.legal = (f3 == 3'd2); end
            7'h23: begin r.cls = C_SW;  r.bsel = 1'b1; r.imm = 3'd1; r.legal = (f3 == 3'd2); end
            7'h63: begin
                r.cls = C_BR; r.imm = 3'd2; r.asel = 1'b1; r.bsel = 1'b1;
                r.legal = (f3 != 3'd2) && (f3 != 3'd3);
            end
            7'h6f: begin r.cls = C_JAL; r.imm = 3'd4; r.asel = 1'b1; r.bsel = 1'b1; r.legal = 1'b1; end
            7'h67: begin r.cls = C_JALR; r.bsel = 1'b1; r.legal = (f3 == 3'd0); end
            7'h37: begin r.cls = C_LUI; r.imm = 3'd3; r.bsel = 1'b1; r.alu = 4'd10; r.legal = 1'b1; end
            7'h17: begin r.cls = C_AUIPC; r.imm = 3'd3; r.asel = 1'b1; r.bsel = 1'b1; r.legal = 1'b1; end
            default: begin r.cls = C_BAD; r.legal = 1'b0; end
        endcase
        return r;
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic bq, input logic bl);
        case (f3)
            3'd0:       return bq;
            3'd1:       return !bq;
            3'd4, 3'd6: return bl;
            default:    return !bl;
        endcase
    endfunction

    function automatic exp_t blank(input logic [2:0] st);
        exp_t e;
        e    = '0;
        e.st = st;
        return e;
    endfunction

    function automatic exp_t with_sel(input exp_t e0, input ref_t r);
        exp_t e;
        e      = e0;
        e.imm  = r.imm;
        e.asel = r.asel;
        e.bsel = r.bsel;
        e.alu  = r.alu;
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] i;
        int          k;
        i = $urandom;
        k = $urandom_range(0, 3);
        case ($urandom_range(0, 9))
            0: begin i[6:0] = 7'h33; i[31:25] = (k < 2) ? 7'h00 : (k == 2) ? 7'h20 : i[31:25]; end
            1: begin i[6:0] = 7'h13; i[31:25] = (k < 2) ? 7'h00 : (k == 2) ? 7'h20 : i[31:25]; end
            2: begin i[6:0] = 7'h03; if (k != 0) i[14:12] = 3'd2; end
            3: begin i[6:0] = 7'h23; if (k != 0) i[14:12] = 3'd2; end
            4: i[6:0] = 7'h63;
            5: i[6:0] = 7'h6f;
            6: begin i[6:0] = 7'h67; if (k != 0) i[14:12] = 3'd0; end
            7: i[6:0] = 7'h37;
            8: i[6:0] = 7'h17;
            default: ;
        endcase
        return i;
    endfunction

    task automatic check_output(input string tag, input exp_t e);
        n_asserts++;
        assert (obs === e) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    task automatic apply_stimulus(input string tag, input exp_t e, input logic mr);
        mem_ready = mr;
        @(negedge clk);
        check_output(tag, e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        #2;
        rst       = 1'b1;
        mem_ready = 1'b1;
        #1;
        check_output({tag, "/rst_async"}, blank(3'd0));
        @(posedge clk);
        #1;
        check_output({tag, "/rst_held"}, blank(3'd0));
        rst = 1'b0;
    endtask

    // Walks one instruction from FETCH to its return to FETCH, checking every cycle
    task automatic run_instr(input string tag, input logic [31:0] ins, input int fw, input int mw,
                             input logic bq, input logic bl, input logic abort_mem);
        ref_t r;
        exp_t e;
        r    = ref_decode(ins);
        breq = bq;
        brlt = bl;
        for (int k = 0; k < fw; k++) begin
            e = blank(3'd0); e.mreq = 1'b1;
            apply_stimulus({tag, "/fetch_wait"}, e, 1'b0);
        end
        e = blank(3'd0); e.mreq = 1'b1; e.irwe = 1'b1;
        apply_stimulus({tag, "/fetch"}, e, 1'b1);
        instr = ins;
        e = blank(3'd1); e.imm = r.imm;
        apply_stimulus({tag, "/decode"}, e, 1'($urandom_range(0, 1)));
        if (!r.legal) begin
            for (int k = 0; k < 3; k++) begin
                e = blank(3'd5); e.ill = 1'b1;
                apply_stimulus({tag, "/trap"}, e, 1'($urandom_range(0, 1)));
            end
            do_reset(tag);
            return;
        end
        e = with_sel(blank(3'd2), r);
        if (r.cls == C_BR) begin
            e.brun  = (ins[14:13] == 2'b11);
            e.pcwe  = 1'b1;
            e.pcsel = branch_taken(ins[14:12], bq, bl);
        end
        apply_stimulus({tag, "/exec"}, e, 1'($urandom_range(0, 1)));
        if (r.cls == C_BR) return;
        if (r.cls == C_LW || r.cls == C_SW) begin
            for (int k = 0; k < mw; k++) begin
                e = with_sel(blank(3'd3), r); e.mreq = 1'b1; e.mwe = (r.cls == C_SW);
                apply_stimulus({tag, "/mem_wait"}, e, 1'b0);
            end
            if (abort_mem) begin
                do_reset(tag);
                return;
            end
            e = with_sel(blank(3'd3), r); e.mreq = 1'b1; e.mwe = (r.cls == C_SW);
            e.pcwe = (r.cls == C_SW);
            apply_stimulus({tag, "/mem"}, e, 1'b1);
            if (r.cls == C_SW) return;
        end
        e = with_sel(blank(3'd4), r);
        e.regwe = 1'b1;
        e.pcwe  = 1'b1;
        e.pcsel = (r.cls == C_JAL || r.cls == C_JALR);
        e.wb    = (r.cls == C_LW) ? 2'd0 : (e.pcsel ? 2'd2 : 2'd1);
        apply_stimulus({tag, "/wb"}, e, 1'($urandom_range(0, 1)));
    endtask

    initial begin
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset", blank(3'd0));
        rst = 1'b0;

        run_instr("add",       32'h002081B3, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr("bne_taken", 32'h00209463, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr("bne_not",   32'h00209463, 0, 0, 1'b1, 1'b0, 1'b0);
        run_instr("lw_wait",   32'h0000A283, 2, 3, 1'b0, 1'b0, 1'b0);
        run_instr("sw",        32'h0020A223, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr("jalr",      32'h000100E7, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr("jalr_bad",  32'h000110E7, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr("sw_rst",    32'h0020A223, 1, 2, 1'b0, 1'b0, 1'b1);
        run_instr("add_after", 32'h002081B3, 0, 0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 200; i++)
            run_instr("rand", gen_instr(), $urandom_range(0, 2), $urandom_range(0, 2),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);

        run_instr("add_final", 32'h002081B3, 0, 0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
